// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// No logic: owner encoding, default address width, starvation limit.
// Imported by the interface, the arbiter top and the starvation counter.
package imem_pkg;

    localparam int AW_DEF         = 12;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 4;

    // Who owns the SRAM read port response slot one cycle after a grant
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_L    = 2'd2
    } owner_e;

    // Word-aligned byte address check for fetches
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, LSU and SRAM-macro signals seen by the arbiter.
// No logic; the slave view is the arbiter, the master view is IFU/LSU/SRAM.
// Valid/ready handshakes on both request ports, fixed 1-cycle response.
interface imem_arbiter_if #(
    parameter int AW = imem_pkg::AW_DEF
);
    // Fetch request / response
    logic          f_req_vld;
    logic [31:0]   f_addr;
    logic          f_rdy;
    logic          f_resp_vld;
    logic [31:0]   f_resp_data;
    logic          f_resp_err;
    logic          flush;

    // LSU / loader request / response
    logic          l_req_vld;
    logic          l_wr;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic [3:0]    l_wstrb;
    logic          l_rdy;
    logic          l_resp_vld;
    logic [31:0]   l_resp_data;

    // SRAM macro
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  f_req_vld, f_addr, flush,
        output f_rdy, f_resp_vld, f_resp_data, f_resp_err,
        input  l_req_vld, l_wr, l_addr, l_wdata, l_wstrb,
        output l_rdy, l_resp_vld, l_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req_vld, f_addr, flush,
        input  f_rdy, f_resp_vld, f_resp_data, f_resp_err,
        output l_req_vld, l_wr, l_addr, l_wdata, l_wstrb,
        input  l_rdy, l_resp_vld, l_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_arbiter_starve_cnt.sv
// Saturating count of LSU wins while a fetch waits; flags when fetch must go next.
// State updates on the clock edge; force_fetch_o is a decode of the current count.
// No backpressure of its own; it only steers the arbiter's priority.
module arb_starve_cnt
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic f_pend_i,
    input  logic f_grant_i,
    input  logic l_grant_i,
    output logic force_fetch_o
);

    localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Next count: clear when fetch is served or idle, bump on each LSU win over a waiting fetch
    always_comb begin
        cnt_d = cnt_q;
        if (f_grant_i || !f_pend_i) begin
            cnt_d = '0;
        end else if (l_grant_i && (cnt_q != SMAX)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch_o = (cnt_q == SMAX);

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction SRAM between fetch and LSU, one grant per cycle.
// Grant drives the SRAM in the same cycle; the tagged response follows exactly 1 cycle later.
// rdy is combinational from vld/flush/starvation; LSU wins unless fetch has waited STARVE_MAX grants.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    imem_arbiter_if.slave bus
);

    owner_e own_q, own_d;
    logic   err_q, err_d;     // pending fetch response is a misalignment error
    logic   lwr_q, lwr_d;     // pending LSU response is a write ack
    logic   rst_q;            // one-cycle quiet window after reset

    logic   grant_en;
    logic   f_elig;
    logic   grant_f;
    logic   grant_l;
    logic   f_aligned;
    logic   force_fetch;

    // Grants are suppressed during reset and in the cycle right after it
    assign grant_en  = !rst && !rst_q;
    assign f_aligned = is_aligned(bus.f_addr[1:0]);
    assign f_elig    = bus.f_req_vld && !bus.flush && grant_en;

    // Fetch wins when it is alone or has been starved long enough; LSU takes everything else
    assign grant_f = f_elig && (!bus.l_req_vld || force_fetch);
    assign grant_l = bus.l_req_vld && grant_en && !grant_f;

    assign bus.f_rdy = grant_f;
    assign bus.l_rdy = grant_l;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk           (clk),
        .rst           (rst),
        .f_pend_i      (bus.f_req_vld),
        .f_grant_i     (grant_f),
        .l_grant_i     (grant_l),
        .force_fetch_o (force_fetch)
    );

    // SRAM drive for the granted requester; a misaligned fetch holds the slot but leaves the macro idle
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_f) begin
            bus.mem_en   = f_aligned;
            bus.mem_addr = bus.f_addr[AW+1:2];
        end else if (grant_l) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.l_addr[AW+1:2];
            if (bus.l_wr) begin
                bus.mem_we    = bus.l_wstrb;
                bus.mem_wdata = bus.l_wdata;
            end
        end
    end

    // Owner and response attributes captured at grant time
    always_comb begin
        own_d = OWN_NONE;
        err_d = 1'b0;
        lwr_d = 1'b0;
        if (grant_f) begin
            own_d = OWN_F;
            err_d = !f_aligned;
        end else if (grant_l) begin
            own_d = OWN_L;
            lwr_d = bus.l_wr;
        end
    end

    // Response-slot state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            own_q <= OWN_NONE;
            err_q <= 1'b0;
            lwr_q <= 1'b0;
            rst_q <= 1'b1;
        end else begin
            own_q <= own_d;
            err_q <= err_d;
            lwr_q <= lwr_d;
            rst_q <= 1'b0;
        end
    end

    // Responses: reset discards in-flight data, flush kills fetch responses, data is zero when not valid
    always_comb begin
        bus.f_resp_vld  = !rst && (own_q == OWN_F) && !bus.flush;
        bus.f_resp_err  = bus.f_resp_vld && err_q;
        bus.f_resp_data = (bus.f_resp_vld && !err_q) ? bus.mem_rdata : 32'h0;
        bus.l_resp_vld  = !rst && (own_q == OWN_L);
        bus.l_resp_data = (bus.l_resp_vld && !lwr_q) ? bus.mem_rdata : 32'h0;
    end

    // Address bits outside the SRAM word range are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.f_addr[31:AW+2], bus.l_addr[31:AW+2], bus.l_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed checks of the instruction-memory arbiter against hand-computed values.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// A small behavioural SRAM with 1-cycle read latency sits on the memory side.
module tb_imem_arbiter;

    localparam int AW = 12;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    imem_arbiter_if #(.AW(AW)) bus ();

    imem_arbiter #(
        .AW         (AW),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: preloaded during reset, byte-masked writes, registered read data
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_r;
    assign bus.mem_rdata = rdata_r;

    always @(posedge clk) begin
        if (rst) begin
            mem[0]  <= 32'h0000_0011;
            mem[1]  <= 32'h0000_0022;
            mem[2]  <= 32'h0000_0033;
            mem[4]  <= 32'h0000_0000;
            mem[8]  <= 32'h5555_AAAA;
            mem[16] <= 32'hDEAD_BEEF;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            rdata_r <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.f_req_vld = 1'b0;
        bus.f_addr    = 32'h0;
        bus.flush     = 1'b0;
        bus.l_req_vld = 1'b0;
        bus.l_wr      = 1'b0;
        bus.l_addr    = 32'h0;
        bus.l_wdata   = 32'h0;
        bus.l_wstrb   = 4'h0;
    endtask

    int exp_cnt [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rdata_r = 32'h0;
        idle_inputs();
        // Requests held high through reset must not be granted
        rst           = 1'b1;
        bus.f_req_vld = 1'b1;
        bus.l_req_vld = 1'b1;
        bus.l_addr    = 32'h40;

        @(negedge clk); #1;
        chk("rst_f_rdy",      bus.f_rdy,      0);
        chk("rst_l_rdy",      bus.l_rdy,      0);
        chk("rst_mem_en",     bus.mem_en,     0);
        chk("rst_mem_we",     bus.mem_we,     0);
        chk("rst_f_resp_vld", bus.f_resp_vld, 0);
        chk("rst_l_resp_vld", bus.l_resp_vld, 0);

        // Cycle after reset: still quiet
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_mem_en", bus.mem_en, 0);
        chk("post_rst_l_rdy",  bus.l_rdy,  0);
        chk("post_rst_f_rdy",  bus.f_rdy,  0);
        chk("post_rst_cnt",    32'(dut.u_starve.cnt_q), 0);

        // Fetch-only stream 0x000, 0x004, 0x008
        @(negedge clk); idle_inputs(); bus.f_req_vld = 1'b1; bus.f_addr = 32'h000; #1;
        chk("fs0_f_rdy",    bus.f_rdy,    1);
        chk("fs0_mem_en",   bus.mem_en,   1);
        chk("fs0_mem_addr", bus.mem_addr, 0);
        chk("fs0_mem_we",   bus.mem_we,   0);
        @(negedge clk); bus.f_addr = 32'h004; #1;
        chk("fs1_f_rdy",    bus.f_rdy,       1);
        chk("fs1_mem_addr", bus.mem_addr,    1);
        chk("fs1_resp_vld", bus.f_resp_vld,  1);
        chk("fs1_resp_dat", bus.f_resp_data, 32'h11);
        @(negedge clk); bus.f_addr = 32'h008; #1;
        chk("fs2_f_rdy",    bus.f_rdy,       1);
        chk("fs2_mem_addr", bus.mem_addr,    2);
        chk("fs2_resp_dat", bus.f_resp_data, 32'h22);
        chk("fs2_mem_we",   bus.mem_we,      0);
        @(negedge clk); bus.f_req_vld = 1'b0; #1;
        chk("fs3_f_rdy",    bus.f_rdy,       0);
        chk("fs3_mem_en",   bus.mem_en,      0);
        chk("fs3_resp_dat", bus.f_resp_data, 32'h33);
        chk("fs3_l_resp",   bus.l_resp_vld,  0);
        @(negedge clk); #1;
        chk("fs4_resp_vld", bus.f_resp_vld, 0);

        // Both held valid: four LSU grants, forced fetch, then LSU again
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.f_req_vld = 1'b1; bus.f_addr = 32'h000;
            bus.l_req_vld = 1'b1; bus.l_wr = 1'b0; bus.l_addr = 32'h040;
            #1;
            chk($sformatf("st%0d_cnt", i),    32'(dut.u_starve.cnt_q), 32'(exp_cnt[i]));
            chk($sformatf("st%0d_f_rdy", i),  bus.f_rdy, (i == 4) ? 1 : 0);
            chk($sformatf("st%0d_l_rdy", i),  bus.l_rdy, (i == 4) ? 0 : 1);
            chk($sformatf("st%0d_l_resp", i), bus.l_resp_vld, (i >= 1 && i <= 4) ? 1 : 0);
            chk($sformatf("st%0d_f_resp", i), bus.f_resp_vld, (i == 5) ? 1 : 0);
            if (i == 1) chk("st1_l_dat", bus.l_resp_data, 32'hDEAD_BEEF);
            if (i == 5) chk("st5_f_dat", bus.f_resp_data, 32'h11);
        end
        @(negedge clk); idle_inputs(); #1;
        chk("st6_l_resp", bus.l_resp_vld,  1);
        chk("st6_l_dat",  bus.l_resp_data, 32'hDEAD_BEEF);
        chk("st6_cnt",    32'(dut.u_starve.cnt_q), 1);

        // Byte-masked LSU write, then fetch the merged word
        @(negedge clk);
        bus.l_req_vld = 1'b1; bus.l_wr = 1'b1; bus.l_addr = 32'h010;
        bus.l_wdata = 32'hAABB_CCDD; bus.l_wstrb = 4'b0011;
        #1;
        chk("wr_l_rdy",   bus.l_rdy,     1);
        chk("wr_mem_we",  bus.mem_we,    4'b0011);
        chk("wr_addr",    bus.mem_addr,  4);
        chk("wr_wdata",   bus.mem_wdata, 32'hAABB_CCDD);
        @(negedge clk); idle_inputs(); bus.f_req_vld = 1'b1; bus.f_addr = 32'h010; #1;
        chk("wr_ack_vld", bus.l_resp_vld,  1);
        chk("wr_ack_dat", bus.l_resp_data, 0);
        chk("wr_f_rdy",   bus.f_rdy,       1);
        chk("wr_f_addr",  bus.mem_addr,    4);
        chk("wr_f_we",    bus.mem_we,      0);
        @(negedge clk); idle_inputs(); #1;
        chk("wr_f_dat",   bus.f_resp_data, 32'h0000_CCDD);

        // Fetch accepted, flushed next cycle while an LSU read proceeds
        @(negedge clk); bus.f_req_vld = 1'b1; bus.f_addr = 32'h020; #1;
        chk("fl_f_rdy0", bus.f_rdy, 1);
        @(negedge clk);
        bus.flush = 1'b1; bus.f_addr = 32'h024;
        bus.l_req_vld = 1'b1; bus.l_wr = 1'b0; bus.l_addr = 32'h040;
        #1;
        chk("fl_f_rdy1",  bus.f_rdy,      0);
        chk("fl_f_resp",  bus.f_resp_vld, 0);
        chk("fl_l_rdy",   bus.l_rdy,      1);
        chk("fl_mem_adr", bus.mem_addr,   16);
        @(negedge clk); idle_inputs(); #1;
        chk("fl_l_resp",  bus.l_resp_vld,  1);
        chk("fl_l_dat",   bus.l_resp_data, 32'hDEAD_BEEF);
        chk("fl_f_resp2", bus.f_resp_vld,  0);

        // Misaligned fetch
        @(negedge clk); bus.f_req_vld = 1'b1; bus.f_addr = 32'h022; #1;
        chk("mis_f_rdy",  bus.f_rdy,  1);
        chk("mis_mem_en", bus.mem_en, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("mis_vld", bus.f_resp_vld,  1);
        chk("mis_err", bus.f_resp_err,  1);
        chk("mis_dat", bus.f_resp_data, 0);

        // Reset pulsed the cycle after an LSU read grant
        @(negedge clk);
        bus.f_req_vld = 1'b1; bus.f_addr = 32'h000;
        bus.l_req_vld = 1'b1; bus.l_wr = 1'b0; bus.l_addr = 32'h040;
        #1;
        chk("rr_l_rdy", bus.l_rdy, 1);
        @(negedge clk); rst = 1'b1; bus.l_req_vld = 1'b0; #1;
        chk("rr_cnt_pre", 32'(dut.u_starve.cnt_q), 1);
        chk("rr_l_resp",  bus.l_resp_vld, 0);
        chk("rr_f_rdy",   bus.f_rdy,      0);
        chk("rr_mem_en",  bus.mem_en,     0);
        @(negedge clk); rst = 1'b0; bus.l_req_vld = 1'b1; #1;
        chk("ra_l_resp", bus.l_resp_vld, 0);
        chk("ra_f_resp", bus.f_resp_vld, 0);
        chk("ra_mem_en", bus.mem_en,     0);
        chk("ra_mem_we", bus.mem_we,     0);
        chk("ra_f_rdy",  bus.f_rdy,      0);
        chk("ra_l_rdy",  bus.l_rdy,      0);
        chk("ra_cnt",    32'(dut.u_starve.cnt_q), 0);
        @(negedge clk); idle_inputs(); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
